// File: rtl/gbapii_bus_cycle_ctrl.sv
// Bus-cycle controller between the 68000 bus and the graphics chip.
// Synchronises the CPU strobes, handshakes with the chip, and drives
// the data-latch strobes, DTACK and a timeout error pulse.
module gbapii_bus_cycle_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic CLK,
   input  logic nRESET,
   input  logic AS_n,
   input  logic UDS_n,
   input  logic LDS_n,
   input  logic RW,
   input  logic sel,
   input  logic chip_ready,
   output logic chip_req,
   output logic chip_we,
   output logic LE,
   output logic OE,
   output logic DTACK_n,
   output logic err
);

   localparam int unsigned WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int unsigned TCW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_LATCH,
      S_ACK
   } state_t;

   state_t         state, next;
   logic           as_meta, as_s;
   logic           uds_meta, uds_s;
   logic           lds_meta, lds_s;
   logic           ds_s;
   logic [1:0]     fill;
   logic           armed;
   logic           rw_q, rw_d;
   logic           time_hit;
   logic [WCW-1:0] wcnt;
   logic [TCW-1:0] tcnt;

   // Two-flop synchronisers for the asynchronous CPU strobes
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         as_meta  <= 1'b1;
         as_s     <= 1'b1;
         uds_meta <= 1'b1;
         uds_s    <= 1'b1;
         lds_meta <= 1'b1;
         lds_s    <= 1'b1;
      end else begin
         as_meta  <= AS_n;
         as_s     <= as_meta;
         uds_meta <= UDS_n;
         uds_s    <= uds_meta;
         lds_meta <= LDS_n;
         lds_s    <= lds_meta;
      end
   end

   assign ds_s = uds_s & lds_s;

   // Arm only once a genuine (post-reset) high AS has been seen, so an
   // AS held low across reset cannot start a second access
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         fill  <= 2'b00;
         armed <= 1'b0;
      end else begin
         fill <= {fill[0], 1'b1};
         if (fill[1] && as_s) armed <= 1'b1;
      end
   end

   // State register, direction latch and registered outputs
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state    <= S_IDLE;
         rw_q     <= 1'b0;
         chip_req <= 1'b0;
         chip_we  <= 1'b0;
         LE       <= 1'b0;
         OE       <= 1'b1;
         DTACK_n  <= 1'b1;
         err      <= 1'b0;
      end else begin
         state    <= next;
         rw_q     <= rw_d;
         chip_req <= (next == S_START) || (next == S_WAIT);
         chip_we  <= ((next == S_START) || (next == S_WAIT)) && !rw_d;
         LE       <= (next == S_LATCH);
         OE       <= !((next == S_ACK) && rw_d);
         DTACK_n  <= !(next == S_ACK);
         err      <= time_hit;
      end
   end

   // Wait (saturating down) and timeout (up) counters
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         wcnt <= '0;
         tcnt <= '0;
      end else if (state == S_START) begin
         wcnt <= WCW'(WAIT_CYCLES);
         tcnt <= '0;
      end else if (state == S_WAIT) begin
         if (wcnt != '0) wcnt <= wcnt - WCW'(1);
         tcnt <= tcnt + TCW'(1);
      end
   end

   // Next-state logic
   always_comb begin
      next     = state;
      rw_d     = rw_q;
      time_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (armed && !as_s && !ds_s && sel) begin
               next = S_START;
               rw_d = RW;
            end
         end
         S_START: begin
            next = as_s ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (as_s) begin
               next = S_IDLE;
            end else if ((wcnt == '0) && chip_ready) begin
               next = rw_q ? S_LATCH : S_ACK;
            end else if (tcnt == TCW'(TIMEOUT - 1)) begin
               next     = S_ACK;
               time_hit = 1'b1;
            end
         end
         S_LATCH: begin
            next = S_ACK;
         end
         S_ACK: begin
            if (as_s) next = S_IDLE;
         end
         default: begin
            next = S_IDLE;
         end
      endcase
   end

endmodule
